// File: rtl/mul_seq.sv
// Multi-cycle RV32M/RV64M integer multiplier (MUL/MULH/MULHSU/MULHU).
// Radix-2^BPC shift-add on operand magnitudes, sign fixed in a final cycle.
module mul_seq #(
    parameter int XLEN = 32,
    parameter int BPC  = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    localparam int N  = XLEN / BPC;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nx;

    logic [1:0]          op_q;
    logic                neg_q;
    logic [2*XLEN-1:0]   mcand;
    logic [XLEN-1:0]     mplier;
    logic [2*XLEN-1:0]   acc;
    logic [CW-1:0]       cnt;

    logic                sa;
    logic                sb;
    logic [XLEN-1:0]     mag_a;
    logic [XLEN-1:0]     mag_b;
    logic [2*XLEN-1:0]   partial;
    logic [2*XLEN-1:0]   prod;
    logic                last;

    // Signedness follows the opcode: rs1 is unsigned only for MULHU,
    // rs2 is signed only for MUL/MULH.
    always_comb begin
        sa    = (op != OP_MULHU) && a[XLEN-1];
        sb    = ((op == OP_MUL) || (op == OP_MULH)) && b[XLEN-1];
        mag_a = sa ? (~a + 1'b1) : a;
        mag_b = sb ? (~b + 1'b1) : b;
    end

    // mcand is pre-shifted each cycle, so the partial product for the current
    // BPC-bit digit only needs the in-digit shift j.
    always_comb begin
        partial = '0;
        for (int j = 0; j < BPC; j++) begin
            if (mplier[j]) partial = partial + (mcand << j);
        end
    end

    assign prod = neg_q ? (~acc + 1'b1) : acc;
    assign last = (cnt == CW'(N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nx = state;
        in_ready = (state == IDLE);
        case (state)
            IDLE:    if (in_valid) state_nx = CALC;
            CALC:    if (last)     state_nx = SIGN;
            SIGN:                  state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default:               state_nx = IDLE;
        endcase
        if (flush) state_nx = IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= '0;
            neg_q     <= 1'b0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            result    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q   <= op;
                        neg_q  <= sa ^ sb;
                        mcand  <= {{XLEN{1'b0}}, mag_a};
                        mplier <= mag_b;
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                CALC: begin
                    acc    <= acc + partial;
                    mcand  <= mcand << BPC;
                    mplier <= mplier >> BPC;
                    cnt    <= cnt + 1'b1;
                end
                SIGN: begin
                    result    <= (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
                    out_valid <= 1'b1;
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: out_valid <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq: eight instances covering XLEN {32,64} x BPC {1,2,4,8},
// directed corner cases, flush/reset aborts, and parallel random traffic against a wide-integer model.
module tb_mul_seq;

    localparam int NCFG = 8;
    localparam int NOPS = 120;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush_s     [NCFG];
    logic        in_valid_s  [NCFG];
    logic        in_ready_s  [NCFG];
    logic        out_valid_s [NCFG];
    logic        out_ready_s [NCFG];
    logic [1:0]  op_s        [NCFG];
    logic [63:0] a_s         [NCFG];
    logic [63:0] b_s         [NCFG];
    logic [63:0] res_s       [NCFG];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NCFG; g++) begin : g_dut
        localparam int XL = (g < 4) ? 32 : 64;
        localparam int BP = 1 << (g % 4);
        logic [XL-1:0] res_l;
        mul_seq #(.XLEN(XL), .BPC(BP)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush     (flush_s[g]),
            .in_valid  (in_valid_s[g]),
            .in_ready  (in_ready_s[g]),
            .op        (op_s[g]),
            .a         (a_s[g][XL-1:0]),
            .b         (b_s[g][XL-1:0]),
            .out_valid (out_valid_s[g]),
            .out_ready (out_ready_s[g]),
            .result    (res_l)
        );
        assign res_s[g] = 64'(res_l);
    end

    function automatic int xlen_of(input int i);
        return (i < 4) ? 32 : 64;
    endfunction

    function automatic int bpc_of(input int i);
        return 1 << (i % 4);
    endfunction

    function automatic logic [63:0] mask_of(input int xl);
        return (xl == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    endfunction

    // Reference: extend each operand to a wide signed integer as the ISA defines,
    // take the full product, then select the low or high XLEN bits.
    function automatic logic [63:0] ref_mul(input logic [1:0] op, input logic [63:0] a,
                                            input logic [63:0] b, input int xl);
        logic signed [129:0] ea;
        logic signed [129:0] eb;
        logic signed [129:0] p;
        logic [129:0]        sh;
        logic                a_signed;
        logic                b_signed;
        a_signed = (op != 2'b11);
        b_signed = (op == 2'b00) || (op == 2'b01);
        if (xl == 32) begin
            ea = {{98{a_signed & a[31]}}, a[31:0]};
            eb = {{98{b_signed & b[31]}}, b[31:0]};
        end else begin
            ea = {{66{a_signed & a[63]}}, a};
            eb = {{66{b_signed & b[63]}}, b};
        end
        p  = ea * eb;
        sh = (op == 2'b00) ? p : (p >> xl);
        return sh[63:0] & mask_of(xl);
    endfunction

    function automatic logic [63:0] rand_operand(input int xl);
        logic [63:0] v;
        case ($urandom_range(0, 7))
            0:       v = '0;
            1:       v = '1;
            2:       v = 64'h1 << (xl - 1);
            3:       v = (64'h1 << (xl - 1)) - 64'h1;
            4:       v = 64'(1);
            default: v = {$urandom, $urandom};
        endcase
        return v & mask_of(xl);
    endfunction

    // One complete transaction on instance i: accept, latency, result, hold
    // with out_ready low (extra in_valid must be ignored), then consume.
    task automatic run_op(input int i, input string name, input logic [1:0] op,
                          input logic [63:0] a, input logic [63:0] b,
                          input int hold, input logic [63:0] exp);
        int          lat;
        int          n;
        logic [63:0] got;
        n = xlen_of(i) / bpc_of(i);
        @(negedge clk);
        op_s[i] = op; a_s[i] = a; b_s[i] = b; in_valid_s[i] = 1'b1;
        checks++;
        if (in_ready_s[i] !== 1'b1) begin
            errors++;
            $display("FAIL %s cfg%0d accept: in_ready=%b expected 1", name, i, in_ready_s[i]);
        end
        @(posedge clk); #1;
        in_valid_s[i] = 1'b0;
        a_s[i] = ~a; b_s[i] = ~b; op_s[i] = ~op;
        checks++;
        if (in_ready_s[i] !== 1'b0 || out_valid_s[i] !== 1'b0) begin
            errors++;
            $display("FAIL %s cfg%0d busy: in_ready=%b out_valid=%b expected 0 0",
                     name, i, in_ready_s[i], out_valid_s[i]);
        end
        lat = 1;
        @(posedge clk); #1;
        while (out_valid_s[i] !== 1'b1 && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat != n + 1) begin
            errors++;
            $display("FAIL %s cfg%0d latency: got %0d edges expected %0d", name, i, lat, n + 1);
        end
        checks++;
        if (res_s[i] !== exp) begin
            errors++;
            $display("FAIL %s cfg%0d result: got %h expected %h (op=%0d a=%h b=%h)",
                     name, i, res_s[i], exp, op, a, b);
        end
        got = res_s[i];
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            in_valid_s[i] = 1'b1;
            a_s[i] = {$urandom, $urandom};
            @(posedge clk); #1;
            checks++;
            if (out_valid_s[i] !== 1'b1 || res_s[i] !== got || in_ready_s[i] !== 1'b0) begin
                errors++;
                $display("FAIL %s cfg%0d hold: out_valid=%b in_ready=%b result=%h expected 1 0 %h",
                         name, i, out_valid_s[i], in_ready_s[i], res_s[i], got);
            end
        end
        @(negedge clk);
        in_valid_s[i] = 1'b0;
        out_ready_s[i] = 1'b1;
        @(posedge clk); #1;
        out_ready_s[i] = 1'b0;
        checks++;
        if (out_valid_s[i] !== 1'b0 || in_ready_s[i] !== 1'b1) begin
            errors++;
            $display("FAIL %s cfg%0d consume: out_valid=%b in_ready=%b expected 0 1",
                     name, i, out_valid_s[i], in_ready_s[i]);
        end
    endtask

    task automatic expect_quiet(input int i, input string name, input int cycles);
        int seen;
        seen = 0;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk); #1;
            if (out_valid_s[i] === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL %s cfg%0d quiet: out_valid seen %0d cycles expected 0", name, i, seen);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < NCFG; i++) begin
            flush_s[i] = 1'b0; in_valid_s[i] = 1'b0; out_ready_s[i] = 1'b0;
            op_s[i] = '0; a_s[i] = '0; b_s[i] = '0;
        end
        rst_n = 1'b0;
        #12;
        for (int i = 0; i < NCFG; i++) begin
            checks++;
            if (out_valid_s[i] !== 1'b0 || res_s[i] !== 64'h0) begin
                errors++;
                $display("FAIL reset cfg%0d: out_valid=%b result=%h expected 0 0",
                         i, out_valid_s[i], res_s[i]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < NCFG; i++) begin
            checks++;
            if (in_ready_s[i] !== 1'b1 || out_valid_s[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_release cfg%0d: in_ready=%b out_valid=%b expected 1 0",
                         i, in_ready_s[i], out_valid_s[i]);
            end
        end
    endtask

    task automatic test_directed();
        run_op(0, "mul_neg",      2'b00, 64'h7,         64'hFFFF_FFFD, 0, 64'hFFFF_FFEB);
        run_op(0, "mulh_neg",     2'b01, 64'h7,         64'hFFFF_FFFD, 0, 64'hFFFF_FFFF);
        run_op(0, "mulhu_max",    2'b11, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 0, 64'hFFFF_FFFE);
        run_op(0, "mul_max",      2'b00, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 0, 64'h0000_0001);
        run_op(0, "mulh_minmin",  2'b01, 64'h8000_0000, 64'h8000_0000, 0, 64'h4000_0000);
        run_op(0, "mulhsu_min",   2'b10, 64'h8000_0000, 64'hFFFF_FFFF, 0, 64'h8000_0000);
        run_op(0, "mulhsu_m1",    2'b10, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 10, 64'hFFFF_FFFF);
        run_op(2, "bpc4_latency", 2'b00, 64'h7,         64'hFFFF_FFFD, 0, 64'hFFFF_FFEB);
        run_op(3, "zero_operand", 2'b01, 64'h0,         64'hDEAD_BEEF, 0, 64'h0);
        run_op(4, "mulh64_m1",    2'b01, '1,            '1,            0, 64'h0);
        run_op(4, "mul64_min",    2'b00, 64'h8000_0000_0000_0000, '1, 0, 64'h8000_0000_0000_0000);
        run_op(7, "mulhu64_max",  2'b11, '1,            '1,            2, 64'hFFFF_FFFF_FFFF_FFFE);
    endtask

    task automatic test_flush();
        logic [63:0] r0;
        int          lat;
        r0 = res_s[0];
        // flush alongside in_valid in IDLE: no accept
        @(negedge clk);
        in_valid_s[0] = 1'b1; flush_s[0] = 1'b1; op_s[0] = 2'b00; a_s[0] = 64'h5; b_s[0] = 64'h3;
        @(posedge clk); #1;
        in_valid_s[0] = 1'b0; flush_s[0] = 1'b0;
        checks++;
        if (in_ready_s[0] !== 1'b1) begin
            errors++;
            $display("FAIL flush_idle: in_ready=%b expected 1", in_ready_s[0]);
        end
        expect_quiet(0, "flush_idle", 40);
        // flush in the 5th CALC cycle
        @(negedge clk);
        in_valid_s[0] = 1'b1;
        @(posedge clk); #1;
        in_valid_s[0] = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        flush_s[0] = 1'b1;
        @(posedge clk); #1;
        flush_s[0] = 1'b0;
        checks++;
        if (in_ready_s[0] !== 1'b1 || out_valid_s[0] !== 1'b0) begin
            errors++;
            $display("FAIL flush_calc: in_ready=%b out_valid=%b expected 1 0",
                     in_ready_s[0], out_valid_s[0]);
        end
        expect_quiet(0, "flush_calc", 40);
        checks++;
        if (res_s[0] !== r0) begin
            errors++;
            $display("FAIL flush_calc_result: got %h expected %h", res_s[0], r0);
        end
        // flush with out_ready in DONE: discard, result stays
        @(negedge clk);
        in_valid_s[0] = 1'b1; op_s[0] = 2'b00; a_s[0] = 64'h6; b_s[0] = 64'h7;
        @(posedge clk); #1;
        in_valid_s[0] = 1'b0;
        lat = 0;
        while (out_valid_s[0] !== 1'b1 && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (res_s[0] !== 64'd42 || out_valid_s[0] !== 1'b1) begin
            errors++;
            $display("FAIL flush_done_pre: out_valid=%b result=%h expected 1 %h",
                     out_valid_s[0], res_s[0], 64'd42);
        end
        @(negedge clk);
        flush_s[0] = 1'b1; out_ready_s[0] = 1'b1;
        @(posedge clk); #1;
        flush_s[0] = 1'b0; out_ready_s[0] = 1'b0;
        checks++;
        if (out_valid_s[0] !== 1'b0 || in_ready_s[0] !== 1'b1 || res_s[0] !== 64'd42) begin
            errors++;
            $display("FAIL flush_done: out_valid=%b in_ready=%b result=%h expected 0 1 %h",
                     out_valid_s[0], in_ready_s[0], res_s[0], 64'd42);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        in_valid_s[0] = 1'b1; op_s[0] = 2'b11; a_s[0] = 64'hFFFF_FFFF; b_s[0] = 64'h2;
        @(posedge clk); #1;
        in_valid_s[0] = 1'b0;
        repeat (32) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid_s[0] !== 1'b0 || res_s[0] !== 64'h0 || in_ready_s[0] !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: out_valid=%b result=%h in_ready=%b expected 0 0 1",
                     out_valid_s[0], res_s[0], in_ready_s[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        expect_quiet(0, "reset_mid", 40);
    endtask

    task automatic random_worker(input int i);
        logic [1:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        int          xl;
        xl = xlen_of(i);
        for (int k = 0; k < NOPS; k++) begin
            op = 2'($urandom_range(0, 3));
            a  = rand_operand(xl);
            b  = rand_operand(xl);
            run_op(i, "random", op, a, b, $urandom_range(0, 3), ref_mul(op, a, b, xl));
        end
    endtask

    task automatic test_back_to_back();
        fork
            random_worker(0);
            random_worker(1);
            random_worker(2);
            random_worker(3);
            random_worker(4);
            random_worker(5);
            random_worker(6);
            random_worker(7);
        join
    endtask

    initial begin
        test_reset();
        test_directed();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
